// File: rtl/piezo_pkg.sv
// piezo_pkg
// Shared definitions for the piezo sequence driver: FSM state and mode
// encodings, the note tables and the constant functions that turn them
// into clock-rate dependent period and duration tables.
// No ports (package).
package piezo_pkg;

    localparam int MAX_NOTES  = 8;
    localparam int FAST_NOTES = 3;

    localparam int PER_W = 16;
    localparam int DUR_W = 27;
    localparam int REP_W = 28;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PLAY = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_ASC  = 2'd0;
    localparam mode_t MODE_DESC = 2'd1;
    localparam mode_t MODE_FAST = 2'd2;

    // Durations are tabulated in clocks of a 50 MHz system and rescaled to
    // the actual clock so that the tempo stays the same at any CLK_HZ.
    localparam longint REF_CLK_HZ = 64'd50_000_000;

    // G6, C7, E7, G7, E7, G7, then padding with G7.
    localparam longint NOTE_FREQ [MAX_NOTES] =
        '{64'd1568, 64'd2093, 64'd2637, 64'd3136,
          64'd2637, 64'd3136, 64'd3136, 64'd3136};

    localparam longint NOTE_DUR_REF [MAX_NOTES] =
        '{64'd8388608, 64'd8388608, 64'd8388608, 64'd12582912,
          64'd4194304, 64'd33554432, 64'd4194304, 64'd4194304};

    typedef logic [MAX_NOTES-1:0][PER_W-1:0] period_tab_t;
    typedef logic [MAX_NOTES-1:0][DUR_W-1:0] dur_tab_t;

    // Period in clocks, rounded to nearest.
    function automatic period_tab_t build_periods(longint clk_hz);
        period_tab_t tab;
        for (int i = 0; i < MAX_NOTES; i++) begin
            tab[i] = PER_W'((clk_hz + NOTE_FREQ[i] / 2) / NOTE_FREQ[i]);
        end
        return tab;
    endfunction

    function automatic dur_tab_t build_durs(longint clk_hz);
        dur_tab_t tab;
        for (int i = 0; i < MAX_NOTES; i++) begin
            tab[i] = DUR_W'((NOTE_DUR_REF[i] * clk_hz) / REF_CLK_HZ);
        end
        return tab;
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// piezo_tone_gen
// Square-wave generator for one note: a period counter that wraps at
// period-1 and a duty compare whose threshold is period >> (4-vol).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   period      note period in clocks
//   vol         0 mute, 1 12.5%, 2 25%, 3 50% high time
//   en          counting enabled (tune playing); counter held at 0 otherwise
//   restart     clear the counter so a new note starts at phase 0
//   piezo       tone output
module piezo_tone_gen
    import piezo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PER_W-1:0] period,
    input  logic [1:0]       vol,
    input  logic             en,
    input  logic             restart,
    output logic             piezo
);

    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] high_time;

    always_comb begin
        case (vol)
            2'd3:    high_time = period >> 1;
            2'd2:    high_time = period >> 2;
            2'd1:    high_time = period >> 3;
            default: high_time = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || restart) begin
            cnt <= '0;
        end else if (cnt >= period - PER_W'(1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PER_W'(1);
        end
    end

    assign piezo = en && (vol != 2'd0) && (cnt < high_time);

endmodule

// File: rtl/piezo_seq_drv.sv
// piezo_seq_drv
// Table-driven note sequencer for a complementary piezo pair. Arbitrates
// between the overspeed alarm (notes 0..2 looping), the battery-low tune
// (descending) and the steering-enabled tune (ascending), then leaves a
// programmable silent gap before re-arbitrating.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en_steer    request ascending tune
//   batt_low    request descending tune
//   too_fast    request overspeed alarm, preempts the other tunes
//   vol         duty-cycle volume
//   piezo       piezo drive
//   piezo_n     complement of piezo while playing, 0 otherwise
//   busy        high exactly while in PLAY
//   note_idx    index of the note currently playing
module piezo_seq_drv
    import piezo_pkg::*;
#(
    parameter int NUM_NOTES  = 6,
    parameter int CLK_HZ     = 50_000_000,
    parameter int REPEAT_SEC = 3,
    parameter int FAST_SIM   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_steer,
    input  logic       batt_low,
    input  logic       too_fast,
    input  logic [1:0] vol,
    output logic       piezo,
    output logic       piezo_n,
    output logic       busy,
    output logic [2:0] note_idx
);

    localparam period_tab_t PERIODS = build_periods(longint'(CLK_HZ));
    localparam dur_tab_t    DURS    = build_durs(longint'(CLK_HZ));

    localparam logic [DUR_W-1:0] DUR_STEP  = (FAST_SIM != 0) ? DUR_W'(64) : DUR_W'(1);
    localparam logic [REP_W-1:0] REP_STEP  = (FAST_SIM != 0) ? REP_W'(64) : REP_W'(1);
    localparam logic [REP_W-1:0] REP_TICKS = REP_W'(longint'(CLK_HZ) * longint'(REPEAT_SEC));

    localparam logic [2:0] IDX_LAST      = 3'(NUM_NOTES - 1);
    localparam logic [2:0] IDX_FAST_LAST = 3'(FAST_NOTES - 1);

    state_t           state, state_nx;
    mode_t            mode, mode_nx;
    logic [2:0]       idx_nx;
    logic [DUR_W-1:0] dur_cnt, dur_nx, dur_next;
    logic [REP_W-1:0] rep_cnt, rep_nx, rep_next;

    logic playing;
    logic note_end;
    logic gap_done;
    logic preempt;
    logic last_note;
    logic tone;

    assign playing  = (state == ST_PLAY);
    assign dur_next = dur_cnt + DUR_STEP;
    assign rep_next = rep_cnt + REP_STEP;
    assign note_end = playing && (dur_next >= DURS[note_idx]);
    assign gap_done = (state == ST_GAP) && (rep_next >= REP_TICKS);

    // The alarm only needs to break into a tune of another kind or a gap;
    // a running alarm simply keeps looping.
    assign preempt = too_fast && ((playing && mode != MODE_FAST) || state == ST_GAP);

    always_comb begin
        case (mode)
            MODE_FAST: last_note = (note_idx == IDX_FAST_LAST);
            MODE_DESC: last_note = (note_idx == 3'd0);
            default:   last_note = (note_idx == IDX_LAST);
        endcase
    end

    // Sequencer next state: arbitration in IDLE, note stepping in PLAY,
    // silent repeat interval in GAP.
    always_comb begin
        state_nx = state;
        mode_nx  = mode;
        idx_nx   = note_idx;
        dur_nx   = dur_cnt;
        rep_nx   = rep_cnt;
        case (state)
            ST_IDLE: begin
                dur_nx = '0;
                rep_nx = '0;
                if (too_fast) begin
                    state_nx = ST_PLAY;
                    mode_nx  = MODE_FAST;
                    idx_nx   = 3'd0;
                end else if (batt_low) begin
                    state_nx = ST_PLAY;
                    mode_nx  = MODE_DESC;
                    idx_nx   = IDX_LAST;
                end else if (en_steer) begin
                    state_nx = ST_PLAY;
                    mode_nx  = MODE_ASC;
                    idx_nx   = 3'd0;
                end
            end
            ST_PLAY: begin
                if (preempt) begin
                    mode_nx = MODE_FAST;
                    idx_nx  = 3'd0;
                    dur_nx  = '0;
                end else if (note_end) begin
                    dur_nx = '0;
                    if (last_note) begin
                        if (mode == MODE_FAST && too_fast) begin
                            idx_nx = 3'd0;
                        end else begin
                            state_nx = ST_GAP;
                            rep_nx   = '0;
                        end
                    end else if (mode == MODE_DESC) begin
                        idx_nx = note_idx - 3'd1;
                    end else begin
                        idx_nx = note_idx + 3'd1;
                    end
                end else begin
                    dur_nx = dur_next;
                end
            end
            ST_GAP: begin
                if (preempt) begin
                    state_nx = ST_PLAY;
                    mode_nx  = MODE_FAST;
                    idx_nx   = 3'd0;
                    dur_nx   = '0;
                    rep_nx   = '0;
                end else if (gap_done) begin
                    state_nx = ST_IDLE;
                    rep_nx   = '0;
                end else begin
                    rep_nx = rep_next;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode     <= MODE_ASC;
            note_idx <= 3'd0;
            dur_cnt  <= '0;
            rep_cnt  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            mode     <= mode_nx;
            note_idx <= idx_nx;
            dur_cnt  <= dur_nx;
            rep_cnt  <= rep_nx;
            busy     <= (state_nx == ST_PLAY);
        end
    end

    piezo_tone_gen u_tone (
        .clk     (clk),
        .rst_n   (rst_n),
        .period  (PERIODS[note_idx]),
        .vol     (vol),
        .en      (playing),
        .restart (playing && (note_end || preempt)),
        .piezo   (tone)
    );

    // Both outputs derive from reset-cleared state, so they drop the
    // moment rst_n falls.
    assign piezo   = tone;
    assign piezo_n = playing && !tone;

endmodule
